// File: rtl/fifo_rd_unpacker.sv
// Pops IN_W-bit FIFO words and emits them as OUT_W-bit valid/ready beats, lowest lane first.
// First beat appears 2 cycles after a pop. Beats are held stable under backpressure, and the next word is prefetched on the last handshake.
module fifo_rd_unpacker #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_empty,
  output logic             o_rden,
  input  logic [IN_W-1:0]  i_rddata,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_last,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_word_cnt
);
  localparam int LANES  = IN_W / OUT_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [IN_W-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_lane;
  logic               rden;
  logic [OUT_W-1:0]   beat;

  assign last_lane = (lane_q == LAST_LANE);

  always_comb begin
    beat = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == LANE_W'(l)) beat = hold_q[l*OUT_W +: OUT_W];
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    rden    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_empty) begin
          rden    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        hold_d  = i_rddata;
        lane_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (i_ready) begin
          if (last_lane) begin
            cnt_d = cnt_q + CNT_W'(1);
            // Prefetch the next word on the final handshake to keep one bubble per word.
            if (!i_empty) begin
              rden    = 1'b1;
              state_d = WAIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      lane_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the state register clears.
  assign o_rden     = rden & ~rstn;
  assign o_valid    = (state_q == SEND) & ~rstn;
  assign o_data     = o_valid ? beat : '0;
  assign o_last     = o_valid & last_lane;
  assign o_busy     = (state_q != IDLE) & ~rstn;
  assign o_word_cnt = cnt_q;

endmodule

// File: doc/fifo_rd_unpacker.md
Name: fifo_rd_unpacker

Overview:
Read-side consumer that sits directly downstream of the 128-bit FIFO. It pops FIFO words when the FIFO is not empty and serialises each word into OUT_W-bit beats on a valid/ready stream. Beats leave least-significant lane first, and the last lane of each word is flagged. The block provides the width conversion between the FIFO and narrower downstream logic.

Parameters:
IN_W, 128, FIFO word width; must be an integer multiple of OUT_W.
OUT_W, 32, output beat width.
LANES, IN_W/OUT_W (derived, localparam), beats per FIFO word.
CNT_W, 16, width of the popped-word counter.

Ports:
clk  input  1  clock; all logic on posedge.
rstn  input  1  synchronous reset, active-high (asserted = 1), sampled on posedge clk.
i_empty  input  1  FIFO empty flag.
o_rden  output  1  FIFO read enable; one pop per cycle asserted.
i_rddata  input  IN_W  FIFO read data; valid exactly 1 cycle after o_rden.
o_valid  output  1  beat valid.
i_ready  input  1  downstream ready.
o_data  output  OUT_W  beat data.
o_last  output  1  high on the final lane (LANES-1) of a word.
o_busy  output  1  high in any state other than IDLE.
o_word_cnt  output  CNT_W  number of words fully emitted (last beat handshaken).

Behaviour:
- Reset (rstn=1 at posedge) has priority over everything. It sets state=IDLE, lane=0, hold=0 and o_word_cnt=0. During reset o_rden, o_valid, o_last and o_busy are 0, and o_data=0.
- Reset mid-word: the partially sent word is discarded. An in-flight FIFO read, where o_rden was high in the cycle before reset, has its data dropped.
- Handshake: a beat transfers on a posedge with o_valid&&i_ready.
  - Once o_valid rises it stays high, and o_data/o_last stay stable, until the transfer.
  - o_valid must not depend combinationally on i_ready.
- o_rden is combinational and is never asserted while i_empty=1. It is high when:
  - state=IDLE and !i_empty, or
  - state=SEND, lane=LANES-1, o_valid&&i_ready, and !i_empty (back-to-back prefetch).
- FSM:
  - IDLE: o_valid=0. If !i_empty, assert o_rden and go to WAIT.
  - WAIT: o_valid=0. Capture i_rddata into hold, set lane=0, go to SEND.
  - SEND: o_valid=1, o_data=hold[lane*OUT_W +: OUT_W], o_last=(lane==LANES-1).
    - On transfer with lane<LANES-1: lane increments; stay in SEND.
    - On transfer with lane=LANES-1: o_word_cnt increments. If !i_empty, go to WAIT (o_rden asserted this cycle); else go to IDLE.
    - With no transfer: hold all state.
- Throughput: LANES beats per word plus 1 bubble cycle (WAIT). Steady state is LANES+1 cycles per word with i_ready tied to 1.
- Latency: i_empty falls at cycle T (block in IDLE) -> o_rden at T -> data captured at T+1 -> first o_valid at T+2.
- o_word_cnt wraps modulo 2^CNT_W with no saturation.
- i_empty rising while in SEND does not affect the current word. It only suppresses the next pop.
- o_busy = (state != IDLE).

Test Plan:
1. Single word: push 128'h4444_4444_3333_3333_2222_2222_1111_1111, i_ready=1 -> o_data sequence 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444 on consecutive cycles. o_last only on 32'h4444_4444. o_word_cnt=1, then IDLE with o_busy=0.
2. Back-to-back: preload 4 words, i_ready=1 -> 16 beats over 20 cycles. Exactly one o_valid=0 cycle between words, 4 o_rden pulses, o_word_cnt=4, no o_rden after the FIFO empties.
3. Backpressure: i_ready toggles 1,0,0,1,… -> o_data/o_last held stable while i_ready=0. No beat lost or duplicated; the beat order matches scenario 1.
4. Empty guard: FIFO empty for 50 cycles -> o_rden never high, o_valid=0, o_busy=0.
5. Reset mid-word: assert rstn after beat 2 of word A, with word B queued -> next cycle o_valid=0 and o_word_cnt=0. After release, word B's beats follow and no remaining beat of A appears.
6. Counter wrap (CNT_W=4): stream 17 words -> o_word_cnt reads 0 after the 16th word and 1 after the 17th.
